opt2_booth_mac: RTL and testbench

//  Parametrised radix-4 Booth MAC for the output-stationary systolic PE; the next generation of the 8-bit carry-save MAC.

---
 rtl/opt2_booth_mac.sv | 148 ++++++++++++++
 tb/tb_opt2_booth_mac.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/opt2_booth_mac.sv
// Radix-4 Booth multiply-accumulate with a carry-save accumulator and a registered
// carry-propagate resolve stage; frames are delimited by in_first/in_last.
module opt2_booth_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int INPUT_PIP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [ACC_WIDTH-1:0]  acc_sum,
  output logic [ACC_WIDTH-1:0]  acc_carry,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_data
);

  localparam int E   = DATA_WIDTH + 2;
  localparam int NPP = E / 2;

  logic                  w_s0_valid;
  logic                  w_s0_first;
  logic                  w_s0_last;
  logic                  w_s0_signed;
  logic [DATA_WIDTH-1:0] w_s0_a;
  logic [DATA_WIDTH-1:0] w_s0_b;

  generate
    if (INPUT_PIP != 0) begin : g_pip
      logic                  r_valid;
      logic                  r_first;
      logic                  r_last;
      logic                  r_signed;
      logic [DATA_WIDTH-1:0] r_a;
      logic [DATA_WIDTH-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_valid <= in_valid;
          r_first <= in_first;
          r_last  <= in_last;
        end
      end

      // Data path registers carry no reset; r_valid qualifies them.
      always_ff @(posedge clk) begin
        r_signed <= in_signed;
        r_a      <= operand_a;
        r_b      <= operand_b;
      end

      assign w_s0_valid  = r_valid;
      assign w_s0_first  = r_first;
      assign w_s0_last   = r_last;
      assign w_s0_signed = r_signed;
      assign w_s0_a      = r_a;
      assign w_s0_b      = r_b;
    end else begin : g_comb
      assign w_s0_valid  = in_valid;
      assign w_s0_first  = in_first;
      assign w_s0_last   = in_last;
      assign w_s0_signed = in_signed;
      assign w_s0_a      = operand_a;
      assign w_s0_b      = operand_b;
    end
  endgenerate

  function automatic logic [ACC_WIDTH-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic [ACC_WIDTH-1:0] m);
    logic [ACC_WIDTH-1:0] pp;
    case (trip)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m << 1;
      3'b100:         pp = -(m << 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  logic [E-1:0]         w_a_ext;
  logic [E-1:0]         w_b_ext;
  logic [E:0]           w_b_pad;
  logic [ACC_WIDTH-1:0] w_mcand;

  assign w_a_ext = w_s0_signed ? {{2{w_s0_a[DATA_WIDTH-1]}}, w_s0_a} : {2'b00, w_s0_a};
  assign w_b_ext = w_s0_signed ? {{2{w_s0_b[DATA_WIDTH-1]}}, w_s0_b} : {2'b00, w_s0_b};
  assign w_b_pad = {w_b_ext, 1'b0};
  assign w_mcand = {{(ACC_WIDTH-E){w_a_ext[E-1]}}, w_a_ext};

  logic [ACC_WIDTH-1:0] r_acc_sum;
  logic [ACC_WIDTH-1:0] r_acc_carry;
  logic                 r_resolve;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;

  logic [ACC_WIDTH-1:0] w_cs_sum   [0:NPP];
  logic [ACC_WIDTH-1:0] w_cs_carry [0:NPP];

  // A first beat restarts from zero instead of the running carry-save pair.
  assign w_cs_sum[0]   = w_s0_first ? '0 : r_acc_sum;
  assign w_cs_carry[0] = w_s0_first ? '0 : r_acc_carry;

  generate
    for (genvar gi = 0; gi < NPP; gi++) begin : g_csa
      logic [ACC_WIDTH-1:0] w_pp;
      assign w_pp = booth_pp(w_b_pad[2*gi+2 -: 3], w_mcand) << (2*gi);
      assign w_cs_sum[gi+1]   = w_cs_sum[gi] ^ w_cs_carry[gi] ^ w_pp;
      assign w_cs_carry[gi+1] = ((w_cs_sum[gi] & w_cs_carry[gi]) |
                                 (w_cs_sum[gi] & w_pp) |
                                 (w_cs_carry[gi] & w_pp)) << 1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_sum   <= '0;
      r_acc_carry <= '0;
      r_resolve   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_s0_valid) begin
        r_acc_sum   <= w_cs_sum[NPP];
        r_acc_carry <= w_cs_carry[NPP];
      end
      r_resolve   <= w_s0_valid & w_s0_last;
      r_out_valid <= r_resolve;
      if (r_resolve) begin
        r_out_data <= r_acc_sum + r_acc_carry;
      end
    end
  end

  assign acc_sum   = r_acc_sum;
  assign acc_carry = r_acc_carry;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_opt2_booth_mac.sv
// Directed bench for opt2_booth_mac: a 32-bit and an 18-bit accumulator instance
// share stimulus; a scoreboard queue holds expected results and due cycles.
module tb_opt2_booth_mac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic        in_signed;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;

  logic [31:0] acc_sum32, acc_carry32, out_data32;
  logic        out_valid32;
  logic [17:0] acc_sum18, acc_carry18, out_data18;
  logic        out_valid18;

  opt2_booth_mac #(.DATA_WIDTH(8), .ACC_WIDTH(32), .INPUT_PIP(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .operand_a(operand_a), .operand_b(operand_b),
    .acc_sum(acc_sum32), .acc_carry(acc_carry32), .out_valid(out_valid32), .out_data(out_data32)
  );

  opt2_booth_mac #(.DATA_WIDTH(8), .ACC_WIDTH(18), .INPUT_PIP(1)) dut18 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .operand_a(operand_a), .operand_b(operand_b),
    .acc_sum(acc_sum18), .acc_carry(acc_carry18), .out_valid(out_valid18), .out_data(out_data18)
  );

  typedef struct {
    logic [31:0] e32;
    logic [17:0] e18;
    int          due;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint model_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int a, input int b, input bit sgn, input bit f, input bit l);
    logic [7:0] a8, b8;
    longint     p;
    a8 = a[7:0];
    b8 = b[7:0];
    if (sgn) p = longint'(signed'(a8)) * longint'(signed'(b8));
    else     p = longint'(a8) * longint'(b8);
    model_acc = f ? p : model_acc + p;
    if (l) sb.push_back('{e32: model_acc[31:0], e18: model_acc[17:0], due: cyc + 3});
    $display("beat a=%0d b=%0d signed=%0d first=%0d last=%0d cyc=%0d", a, b, sgn, f, l, cyc);
    operand_a = a8;
    operand_b = b8;
    in_signed = sgn;
    in_first  = f;
    in_last   = l;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every pulse must match the head entry on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk("pulse_missing_due", 32'(cyc), 32'(e.due));
    end
    if (out_valid32 || out_valid18) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(out_data32), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        $display("result out32=%0d out18=%0d exp32=%0d exp18=%0d cyc=%0d due=%0d",
                 out_data32, out_data18, e.e32, e.e18, cyc, e.due);
        chk("valid32", 32'(out_valid32), 32'd1);
        chk("valid18", 32'(out_valid18), 32'd1);
        chk("data32", out_data32, e.e32);
        chk("data18", 32'(out_data18), 32'(e.e18));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_signed = 1'b0;
    operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid32), 32'd0);
      chk("rst_out_data", out_data32, 32'd0);
      chk("rst_acc_sum", acc_sum32, 32'd0);
      chk("rst_acc_carry", acc_carry32, 32'd0);
      chk("rst_out_valid18", 32'(out_valid18), 32'd0);
    end
    @(posedge clk); #1;

    // Single products, signed and unsigned interpretations of the same bits
    beat(-128, -128, 1'b1, 1'b1, 1'b1);
    idle(4);
    beat(255, 255, 1'b0, 1'b1, 1'b1);
    beat(255, 255, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Multi-beat signed frame with idle gaps
    beat(3, -7, 1'b1, 1'b1, 1'b0);
    idle(2);
    beat(-2, 5, 1'b1, 1'b0, 1'b0);
    idle(1);
    beat(127, 127, 1'b1, 1'b0, 1'b0);
    idle(3);
    beat(-1, 1, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Back-to-back frames without a bubble
    beat(2, 3, 1'b0, 1'b1, 1'b1);
    beat(4, 5, 1'b0, 1'b1, 1'b0);
    beat(1, 1, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Accumulation continues past a last when the next beat is not first
    beat(10, 20, 1'b0, 1'b1, 1'b1);
    beat(1, 2, 1'b0, 1'b0, 1'b0);
    beat(3, 3, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Reset in mid-frame discards the partial sum
    beat(5, 5, 1'b0, 1'b1, 1'b0);
    beat(6, 6, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_acc_sum", acc_sum32, 32'd0);
    chk("midrst_acc_carry", acc_carry32, 32'd0);
    @(posedge clk); #1;
    beat(1, 1, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Three signed -128*-128 beats, then a 17-beat frame that wraps 18 bits
    for (int i = 0; i < 3; i++) beat(-128, -128, 1'b1, i == 0, i == 2);
    idle(4);
    for (int i = 0; i < 17; i++) beat(-128, -128, 1'b1, i == 0, i == 16);
    idle(10);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
